// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the load/store unit.
//   - funct3 access-size encodings (byte/half/word, signed and unsigned)
//   - FSM state encoding used by lsu
package lsu_pkg;

  // funct3 access-size / sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational data-path helpers for the LSU.
//   Request side (driven from the incoming op):
//     req_funct3, req_lane, req_is_load, req_is_store, req_store_data
//       -> st_wdata (lane-replicated store data), st_be (byte enables,
//          0000 for loads), req_illegal (misaligned/illegal access)
//   Response side (driven from the captured op):
//     ld_funct3, ld_lane, ld_rdata -> ld_data (extracted, extended result)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_lane,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [31:0] req_store_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic        req_illegal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  rd_byte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = ld_rdata[8*gi +: 8];
  end

  assign byte_sel = rd_byte[ld_lane];
  // Halfword loads are aligned, so only lane bit 1 selects the half.
  assign half_sel = ld_lane[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  // Store lane replication and byte enables
  always_comb begin
    st_wdata = req_store_data;
    st_be    = 4'b0000;
    if (req_is_store) begin
      case (req_funct3)
        F3_B: begin
          st_wdata = {4{req_store_data[7:0]}};
          st_be    = 4'b0001 << req_lane;
        end
        F3_H: begin
          st_wdata = {2{req_store_data[15:0]}};
          st_be    = 4'b0011 << {req_lane[1], 1'b0};
        end
        F3_W: begin
          st_be    = 4'b1111;
        end
        default: st_be = 4'b0000;
      endcase
    end
  end

  // Legality: conflicting direction, unsupported funct3, or misalignment
  always_comb begin
    req_illegal = 1'b0;
    if (req_is_load && req_is_store) begin
      req_illegal = 1'b1;
    end else if (req_is_load) begin
      case (req_funct3)
        F3_B, F3_BU: req_illegal = 1'b0;
        F3_H, F3_HU: req_illegal = req_lane[0];
        F3_W:        req_illegal = |req_lane;
        default:     req_illegal = 1'b1;
      endcase
    end else if (req_is_store) begin
      case (req_funct3)
        F3_B:    req_illegal = 1'b0;
        F3_H:    req_illegal = req_lane[0];
        F3_W:    req_illegal = |req_lane;
        default: req_illegal = 1'b1;
      endcase
    end
  end

  // Load extraction and sign/zero extension
  always_comb begin
    case (ld_funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'd0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'd0, half_sel};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: multi-cycle load/store unit between execute and a variable-latency
// data memory (request/acknowledge handshake).
//   Core side : valid_in, is_load, is_store, funct3, addr, store_data in;
//               busy (stall), done (1-cycle pulse), load_data, fault out.
//   Memory    : mem_req, mem_we, mem_addr, mem_wdata, mem_be out (all
//               registered); mem_ack, mem_rdata in.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              fault_q, fault_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;

  logic              accept;
  logic [31:0]       st_wdata;
  logic [3:0]        st_be;
  logic              req_illegal;
  logic [31:0]       ld_data;

  lsu_align u_align (
    .req_funct3     (funct3),
    .req_lane       (addr[1:0]),
    .req_is_load    (is_load),
    .req_is_store   (is_store),
    .req_store_data (store_data),
    .st_wdata       (st_wdata),
    .st_be          (st_be),
    .req_illegal    (req_illegal),
    .ld_funct3      (funct3_q),
    .ld_lane        (lane_q),
    .ld_rdata       (mem_rdata),
    .ld_data        (ld_data)
  );

  assign accept = (state_q == LSU_IDLE) && valid_in && (is_load || is_store);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    is_load_d   = is_load_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;

    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          is_load_d = is_load;
          funct3_d  = funct3;
          lane_d    = addr[1:0];
          if (req_illegal) begin
            // Faulting op completes without ever touching memory.
            fault_d     = 1'b1;
            load_data_d = 32'd0;
            state_d     = LSU_RESP;
          end else begin
            fault_d     = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = st_wdata;
            mem_be_d    = st_be;
            state_d     = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (is_load_q) begin
            load_data_d = ld_data;
          end
          state_d = LSU_RESP;
        end
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d   = LSU_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LSU_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'b0000;
      load_data_q <= 32'd0;
      fault_q     <= 1'b0;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
      is_load_q   <= is_load_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
    end
  end

  // busy drops in RESP so the core advances on the done cycle.
  assign busy      = accept || (state_q == LSU_REQ);
  assign done      = (state_q == LSU_RESP);
  assign fault     = done && fault_q;
  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu. The bench acts as the data memory
// (word array indexed by addr[11:2]) and predicts every output from the
// access rules using plain arithmetic.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_m [0:1023];
  logic [31:0] exp_ld;
  logic [31:0] ld_obs;
  logic [31:0] saved;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .load_data(load_data), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit legal(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (ld && st) return 1'b0;
    if (ld) begin
      case (f3)
        3'd0, 3'd4: return 1'b1;
        3'd1, 3'd5: return (a % 2) == 0;
        3'd2:       return (a % 4) == 0;
        default:    return 1'b0;
      endcase
    end
    case (f3)
      3'd0:    return 1'b1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] s;
    logic [31:0] v;
    s = word >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = s & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd4: v = s & 32'hFF;
      3'd1: begin v = s & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd5: v = s & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  // One complete operation: accept, w wait cycles, ack, done, one idle cycle.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int w);
    bit          ok;
    int          idx;
    logic [31:0] wexp;
    logic [3:0]  bexp;
    ok   = legal(ld, st, f3, a);
    idx  = int'(a[11:2]);
    wexp = 32'd0;
    bexp = 4'd0;
    if (st) begin
      case (f3)
        3'd0: begin bexp = 4'(1 << (a % 4)); wexp = (d & 32'hFF) * 32'h01010101;   end
        3'd1: begin bexp = 4'(3 << (a % 4)); wexp = (d & 32'hFFFF) * 32'h00010001; end
        default: begin bexp = 4'hF; wexp = d; end
      endcase
    end

    valid_in = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = d;
    mem_ack = 1'($urandom_range(0, 1));  // stray ack in IDLE must be ignored
    mem_rdata = $urandom;
    #1 chk("busy_accept", {31'd0, busy}, 32'd1);
    step();
    valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
    mem_ack = 1'b0;
    if (!ok) begin
      exp_ld = 32'd0;
      #1;
      chk("fault_done",  {31'd0, done},    32'd1);
      chk("fault_flag",  {31'd0, fault},   32'd1);
      chk("fault_noreq", {31'd0, mem_req}, 32'd0);
      chk("fault_busy",  {31'd0, busy},    32'd0);
      chk("fault_ldata", load_data,        exp_ld);
    end else begin
      for (int c = 0; c <= w; c++) begin
        #1;
        chk("req",      {31'd0, mem_req}, 32'd1);
        chk("req_busy", {31'd0, busy},    32'd1);
        chk("req_done", {31'd0, done},    32'd0);
        chk("req_we",   {31'd0, mem_we},  {31'd0, st});
        chk("req_addr", mem_addr,         a & 32'hFFFFFFFC);
        chk("req_be",   {28'd0, mem_be},  {28'd0, bexp});
        if (st) chk("req_wdata", mem_wdata, wexp);
        mem_ack   = (c == w);
        mem_rdata = (c == w && ld) ? mem_m[idx] : $urandom;
        step();
      end
      mem_ack = 1'b0;
      if (st) begin
        for (int i = 0; i < 4; i++)
          if (bexp[i]) mem_m[idx][8*i +: 8] = wexp[8*i +: 8];
      end else begin
        exp_ld = ext(f3, a, mem_m[idx]);
      end
      #1;
      chk("done",       {31'd0, done},    32'd1);
      chk("done_fault", {31'd0, fault},   32'd0);
      chk("done_busy",  {31'd0, busy},    32'd0);
      chk("done_noreq", {31'd0, mem_req}, 32'd0);
      chk("load_data",  load_data,        exp_ld);
    end
    ld_obs  = load_data;
    mem_ack = 1'($urandom_range(0, 1));  // stray ack in RESP must be ignored
    step();
    #1;
    chk("post_done",  {31'd0, done},    32'd0);
    chk("post_req",   {31'd0, mem_req}, 32'd0);
    chk("post_busy",  {31'd0, busy},    32'd0);
    chk("post_ldata", load_data,        exp_ld);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = $urandom;
    reset = 1'b1; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    exp_ld = 32'd0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_busy",  {31'd0, busy},    32'd0);
    chk("rst_done",  {31'd0, done},    32'd0);
    chk("rst_fault", {31'd0, fault},   32'd0);
    chk("rst_ldata", load_data,        32'd0);
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_we",    {31'd0, mem_we},  32'd0);
    chk("rst_addr",  mem_addr,         32'd0);
    chk("rst_wdata", mem_wdata,        32'd0);
    chk("rst_be",    {28'd0, mem_be},  32'd0);
    step();

    // Directed stores
    do_op(0, 1, 3'd2, 32'h104, 32'hDEADBEEF, 0);
    do_op(0, 1, 3'd0, 32'h203, 32'h000000A5, 0);
    do_op(0, 1, 3'd2, 32'h100, 32'h12F03456, 1);
    // Directed loads with wait states
    do_op(1, 0, 3'd0, 32'h102, 32'd0, 3);
    chk("lb_value", ld_obs, 32'hFFFFFFF0);
    do_op(1, 0, 3'd4, 32'h102, 32'd0, 3);
    chk("lbu_value", ld_obs, 32'h000000F0);
    do_op(1, 0, 3'd5, 32'h102, 32'd0, 2);
    chk("lhu_value", ld_obs, 32'h000012F0);
    do_op(1, 0, 3'd1, 32'h102, 32'd0, 0);
    chk("lh_value", ld_obs, 32'h000012F0);
    // Faults
    do_op(1, 0, 3'd2, 32'h106, 32'd0, 0);
    do_op(0, 1, 3'd3, 32'h100, 32'h11111111, 0);
    do_op(1, 0, 3'd6, 32'h100, 32'd0, 0);
    do_op(1, 1, 3'd2, 32'h100, 32'd0, 0);
    do_op(1, 0, 3'd5, 32'h101, 32'd0, 0);
    do_op(0, 1, 3'd1, 32'h103, 32'h2222, 0);

    // Reset while waiting for ack
    valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h100;
    step();
    valid_in = 1'b0; is_load = 1'b0;
    #1 chk("rstreq_req", {31'd0, mem_req}, 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ld = 32'd0;
    #1;
    chk("rstreq_noreq", {31'd0, mem_req}, 32'd0);
    chk("rstreq_nodone", {31'd0, done},   32'd0);
    chk("rstreq_busy",  {31'd0, busy},    32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    #1;
    chk("late_ack_done", {31'd0, done},    32'd0);
    chk("late_ack_req",  {31'd0, mem_req}, 32'd0);
    chk("late_ack_ld",   load_data,        32'd0);
    step();
    #1 chk("late_ack_done2", {31'd0, done}, 32'd0);

    // Reset asserted together with valid_in
    reset = 1'b1; valid_in = 1'b1; is_load = 1'b1; funct3 = 3'd2; addr = 32'h100;
    step();
    reset = 1'b0; valid_in = 1'b0; is_load = 1'b0;
    #1 chk("rstvalid_req", {31'd0, mem_req}, 32'd0);
    step();
    #1 chk("rstvalid_done", {31'd0, done}, 32'd0);
    chk("rstvalid_req2", {31'd0, mem_req}, 32'd0);

    // Back-to-back store then load of the same word
    saved = $urandom;
    do_op(0, 1, 3'd2, 32'h300, saved, 0);
    do_op(1, 0, 3'd2, 32'h300, 32'd0, 0);
    chk("b2b_load", ld_obs, saved);

    // Randomized operations
    for (int n = 0; n < 120; n++) begin
      int r;
      bit ld, st;
      r  = int'($urandom_range(0, 9));
      ld = (r <= 5);
      st = (r == 0) || (r >= 6);
      do_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
            int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
